cache_way_ctrl: RTL and testbench
=================================

# cache_way_ctrl

Parametrised cache set/way controller between the CPU request port and the tag/data arrays. It decodes each request address into tag, index and offset for the active associativity mode (direct-mapped up to WAYS-way) and emits a way-enable mask and a round-robin victim way. It also owns runtime mode switching: it drains in-flight requests, handshakes a flush with the array controller, then applies the new mode.

## Interface

- ADDR_W, 32, request address width
- OFFSET_W, 4, byte-offset bits
- BASE_INDEX_W, 9, index bits at maximum associativity
- WAYS, 8, physical ways (power of 2, ≥2)
- derived: LOG2_WAYS = $clog2(WAYS), INDEX_W = BASE_INDEX_W + LOG2_WAYS, TAG_W = ADDR_W − OFFSET_W − BASE_INDEX_W, MODE_W = $clog2(LOG2_WAYS+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req_valid  in  1  address request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  ADDR_W  request address
- out_valid  out  1  decoded result valid
- out_ready  in  1  downstream accepts result
- out_tag  out  TAG_W  tag, zero-extended
- out_index  out  INDEX_W  set index, zero-extended
- out_offset  out  OFFSET_W  addr[OFFSET_W-1:0]
- out_way_en  out  WAYS  enabled-way mask
- out_victim  out  LOG2_WAYS  replacement way
- mode_req_valid  in  1  mode change request, held until ack or err
- mode_req  in  MODE_W  requested mode m (2^m ways)
- mode_ack  out  1  one-cycle pulse: mode applied
- mode_err  out  1  one-cycle pulse: mode illegal (m > LOG2_WAYS)
- flush_req  out  1  held high until flush_done
- flush_done  in  1  array flush complete
- cur_mode  out  MODE_W  active mode

## Operation

- Decode for mode m: out_index = addr[OFFSET_W+INDEX_W−m−1 : OFFSET_W]; out_tag = addr[ADDR_W−1 : OFFSET_W+INDEX_W−m]; both zero-extended.
- out_way_en[WAYS−1−k] = 1 for ways k < 2^m (MSB-first; DM = 8'h80, 8-way = 8'hFF).
- Victim counter: increments on each accepted request, wraps at 2^m−1; out_victim is the counter value at acceptance. Reset to 0 on reset and on every mode apply.
- FSM states RUN, DRAIN, FLUSH.
  - RUN: req_ready = !out_valid | out_ready. When mode_req_valid: illegal → mode_err pulse next cycle, stay RUN; equal to cur_mode → mode_ack next cycle, no flush; otherwise latch pending mode, go DRAIN. A request accepted in the same cycle uses the old mode.
  - DRAIN: req_ready = 0; once out_valid = 0 → FLUSH.
  - FLUSH: flush_req = 1; on sampled flush_done: cur_mode ← pending, victim ← 0, flush_req drops, mode_ack pulses, → RUN.
- flush_done outside FLUSH is ignored. mode_req_valid is sampled only in RUN.
- Reset values: state RUN, cur_mode 0, out_valid 0, out_tag/index/offset/way_en/victim 0, flush_req 0, mode_ack 0, mode_err 0. Reset during DRAIN/FLUSH abandons the change: flush_req low the next cycle, mode returns to 0.

## Timing

- Decode latency 1 cycle (registered output stage); full throughput of 1 request/cycle when out_ready = 1.
- Output holds stable while out_valid & !out_ready.
- Mode change, minimum case: accept → DRAIN (1 cycle if empty) → FLUSH → ack in the cycle after flush_done. First request under the new mode is accepted in the cycle after mode_ack.
- mode_ack and mode_err are registered single-cycle pulses.

## Structure

- Package cache_pkg: FSM state enum, derived-width localparam functions, the legal-mode check.
- Sub-module cache_addr_decode: combinational (addr, mode) → tag/index/offset/way_en. Instantiated once, feeding the output register.

## Test plan

- Defaults, mode 0, addr 0xDEADBEEF → next cycle tag 0x0DEAD, index 0xBEE, offset 0xF, way_en 0x80, victim 0.
- Switch to mode 3 with immediate flush_done, then addr 0xDEADBEEF → tag 0x6F56D, index 0x1EE, way_en 0xFF, cur_mode 3.
- Mode 2, five back-to-back requests → victims 0,1,2,3,0; way_en 0xF0.
- Result pending with out_ready low for 3 cycles plus a mode request → req_ready 0, flush_req rises only after the output handshake, ack the cycle after flush_done.
- WAYS=4, mode_req 3 → mode_err pulse, no flush_req, cur_mode unchanged; re-requesting the current mode → mode_ack with no flush.
- Reset asserted in FLUSH → flush_req low next cycle, cur_mode 0, out_valid 0, victim 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache set/way controller.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } way_state_e;

  function automatic int unsigned calc_tag_w(int unsigned addr_w, int unsigned offset_w,
                                             int unsigned base_index_w);
    return addr_w - offset_w - base_index_w;
  endfunction

  function automatic int unsigned calc_mode_w(int unsigned log2_ways);
    return $clog2(log2_ways + 1);
  endfunction

  // Mode m selects 2^m ways, so it cannot exceed log2 of the physical way count.
  function automatic logic mode_legal(int unsigned mode, int unsigned log2_ways);
    return mode <= log2_ways;
  endfunction

endpackage

// File: rtl/cache_addr_decode.sv
// Combinational address split and way-enable mask for a given associativity mode.
module cache_addr_decode
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned OFFSET_W     = 4,
  parameter int unsigned BASE_INDEX_W = 9,
  parameter int unsigned WAYS         = 8,
  localparam int unsigned LOG2_WAYS   = $clog2(WAYS),
  localparam int unsigned INDEX_W     = BASE_INDEX_W + LOG2_WAYS,
  localparam int unsigned TAG_W       = calc_tag_w(ADDR_W, OFFSET_W, BASE_INDEX_W),
  localparam int unsigned MODE_W      = calc_mode_w(LOG2_WAYS)
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [MODE_W-1:0]   mode,
  output logic [TAG_W-1:0]    tag,
  output logic [INDEX_W-1:0]  index,
  output logic [OFFSET_W-1:0] offset,
  output logic [WAYS-1:0]     way_en
);

  logic [INDEX_W-1:0] index_full;

  // Each extra associativity bit moves one index bit into the tag.
  always_comb begin
    index_full = INDEX_W'(addr >> OFFSET_W);
    index      = index_full & ({INDEX_W{1'b1}} >> mode);
    tag        = TAG_W'(addr >> (OFFSET_W + INDEX_W - 32'(mode)));
    offset     = addr[OFFSET_W-1:0];
    way_en     = ~({WAYS{1'b1}} >> (32'd1 << mode));
  end

endmodule

// File: rtl/cache_way_ctrl.sv
// Cache set/way controller: registered address decode, round-robin victim,
// and drain/flush sequencing for runtime associativity changes.
module cache_way_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned OFFSET_W     = 4,
  parameter int unsigned BASE_INDEX_W = 9,
  parameter int unsigned WAYS         = 8,
  localparam int unsigned LOG2_WAYS   = $clog2(WAYS),
  localparam int unsigned INDEX_W     = BASE_INDEX_W + LOG2_WAYS,
  localparam int unsigned TAG_W       = calc_tag_w(ADDR_W, OFFSET_W, BASE_INDEX_W),
  localparam int unsigned MODE_W      = calc_mode_w(LOG2_WAYS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [INDEX_W-1:0]   out_index,
  output logic [OFFSET_W-1:0]  out_offset,
  output logic [WAYS-1:0]      out_way_en,
  output logic [LOG2_WAYS-1:0] out_victim,
  input  logic                 mode_req_valid,
  input  logic [MODE_W-1:0]    mode_req,
  output logic                 mode_ack,
  output logic                 mode_err,
  output logic                 flush_req,
  input  logic                 flush_done,
  output logic [MODE_W-1:0]    cur_mode
);

  way_state_e           state;
  logic [MODE_W-1:0]    pend_mode;
  logic [LOG2_WAYS-1:0] vic_cnt;
  logic [LOG2_WAYS-1:0] vic_max;
  logic [LOG2_WAYS-1:0] vic_next;
  logic                 accept;
  logic [TAG_W-1:0]     dec_tag;
  logic [INDEX_W-1:0]   dec_index;
  logic [OFFSET_W-1:0]  dec_offset;
  logic [WAYS-1:0]      dec_way_en;

  cache_addr_decode #(
    .ADDR_W       (ADDR_W),
    .OFFSET_W     (OFFSET_W),
    .BASE_INDEX_W (BASE_INDEX_W),
    .WAYS         (WAYS)
  ) u_decode (
    .addr   (req_addr),
    .mode   (cur_mode),
    .tag    (dec_tag),
    .index  (dec_index),
    .offset (dec_offset),
    .way_en (dec_way_en)
  );

  assign req_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept    = req_valid && req_ready;
  assign vic_max   = LOG2_WAYS'((32'd1 << cur_mode) - 32'd1);
  assign vic_next  = (vic_cnt == vic_max) ? '0 : vic_cnt + LOG2_WAYS'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      pend_mode  <= '0;
      cur_mode   <= '0;
      vic_cnt    <= '0;
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_index  <= '0;
      out_offset <= '0;
      out_way_en <= '0;
      out_victim <= '0;
      flush_req  <= 1'b0;
      mode_ack   <= 1'b0;
      mode_err   <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      mode_err <= 1'b0;

      if (accept) begin
        out_valid  <= 1'b1;
        out_tag    <= dec_tag;
        out_index  <= dec_index;
        out_offset <= dec_offset;
        out_way_en <= dec_way_en;
        out_victim <= vic_cnt;
        vic_cnt    <= vic_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // The request stays asserted through its ack/err pulse, so skip that cycle.
      case (state)
        ST_RUN: begin
          if (mode_req_valid && !mode_ack && !mode_err) begin
            if (!mode_legal(32'(mode_req), LOG2_WAYS)) begin
              mode_err <= 1'b1;
            end else if (mode_req == cur_mode) begin
              mode_ack <= 1'b1;
            end else begin
              pend_mode <= mode_req;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!out_valid) begin
            flush_req <= 1'b1;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            cur_mode  <= pend_mode;
            vic_cnt   <= '0;
            flush_req <= 1'b0;
            mode_ack  <= 1'b1;
            state     <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed bench for cache_way_ctrl: 8-way instance plus a 4-way instance for illegal modes.
module tb_cache_way_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, out_valid, out_ready;
  logic [31:0] req_addr;
  logic [18:0] out_tag;
  logic [11:0] out_index;
  logic [3:0]  out_offset;
  logic [7:0]  out_way_en;
  logic [2:0]  out_victim;
  logic        mode_req_valid, mode_ack, mode_err, flush_req, flush_done;
  logic [1:0]  mode_req, cur_mode;

  logic        req_valid4, req_ready4, out_valid4, out_ready4;
  logic [31:0] req_addr4;
  logic [18:0] out_tag4;
  logic [10:0] out_index4;
  logic [3:0]  out_offset4;
  logic [3:0]  out_way_en4;
  logic [1:0]  out_victim4;
  logic        mode_req_valid4, mode_ack4, mode_err4, flush_req4, flush_done4;
  logic [1:0]  mode_req4, cur_mode4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_way_ctrl u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_index(out_index), .out_offset(out_offset), .out_way_en(out_way_en),
    .out_victim(out_victim), .mode_req_valid(mode_req_valid), .mode_req(mode_req),
    .mode_ack(mode_ack), .mode_err(mode_err), .flush_req(flush_req),
    .flush_done(flush_done), .cur_mode(cur_mode)
  );

  cache_way_ctrl #(.WAYS(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_addr(req_addr4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_tag(out_tag4),
    .out_index(out_index4), .out_offset(out_offset4), .out_way_en(out_way_en4),
    .out_victim(out_victim4), .mode_req_valid(mode_req_valid4), .mode_req(mode_req4),
    .mode_ack(mode_ack4), .mode_err(mode_err4), .flush_req(flush_req4),
    .flush_done(flush_done4), .cur_mode(cur_mode4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  // Mode change with flush_done held high; returns cycles until mode_ack.
  task automatic change_mode(input logic [1:0] m, output int cyc);
    mode_req_valid = 1'b1;
    mode_req       = m;
    flush_done     = 1'b1;
    cyc            = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (mode_ack || mode_err) break;
    end
    chk("mode_ack_seen", 32'(mode_ack), 32'd1);
    mode_req_valid = 1'b0;
    flush_done     = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [2:0] exp_vic [5];
    exp_vic = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; out_ready = 1'b1;
    mode_req_valid = 1'b0; mode_req = '0; flush_done = 1'b0;
    req_valid4 = 1'b0; req_addr4 = '0; out_ready4 = 1'b1;
    mode_req_valid4 = 1'b0; mode_req4 = '0; flush_done4 = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cur_mode", 32'(cur_mode), 32'd0);
    chk("rst_flush_req", 32'(flush_req), 32'd0);
    chk("rst_way_en", 32'(out_way_en), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    reset = 1'b1;
    step();
    chk("req_ready_idle", 32'(req_ready), 32'd1);

    // Direct-mapped decode
    send(32'hDEADBEEF);
    chk("m0_valid", 32'(out_valid), 32'd1);
    chk("m0_tag", 32'(out_tag), 32'h0DEAD);
    chk("m0_index", 32'(out_index), 32'hBEE);
    chk("m0_offset", 32'(out_offset), 32'hF);
    chk("m0_way_en", 32'(out_way_en), 32'h80);
    chk("m0_victim", 32'(out_victim), 32'd0);

    // Switch to 8-way with immediate flush_done
    change_mode(2'd3, cyc);
    chk("m3_ack_latency", 32'(cyc), 32'd3);
    chk("m3_cur_mode", 32'(cur_mode), 32'd3);
    step();
    chk("m3_ack_pulse", 32'(mode_ack), 32'd0);
    chk("m3_flush_low", 32'(flush_req), 32'd0);
    send(32'hDEADBEEF);
    chk("m3_tag", 32'(out_tag), 32'h6F56D);
    chk("m3_index", 32'(out_index), 32'h1EE);
    chk("m3_way_en", 32'(out_way_en), 32'hFF);
    chk("m3_victim", 32'(out_victim), 32'd0);

    // 4-way: round-robin victim over back-to-back requests
    change_mode(2'd2, cyc);
    chk("m2_cur_mode", 32'(cur_mode), 32'd2);
    step();
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr = 32'h1000 + 32'(i * 16);
      step();
      chk($sformatf("m2_victim%0d", i), 32'(out_victim), 32'(exp_vic[i]));
      chk($sformatf("m2_way_en%0d", i), 32'(out_way_en), 32'hF0);
    end
    req_valid = 1'b0;
    step();

    // Stalled output with a pending mode change
    out_ready = 1'b0;
    send(32'h12345678);
    chk("st_tag", 32'(out_tag), 32'h48D1);
    chk("st_index", 32'(out_index), 32'h167);
    chk("st_victim", 32'(out_victim), 32'd1);
    mode_req_valid = 1'b1;
    mode_req = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_req_ready", 32'(req_ready), 32'd0);
      chk("st_flush_req", 32'(flush_req), 32'd0);
      chk("st_hold_tag", 32'(out_tag), 32'h48D1);
    end
    out_ready = 1'b1;
    step();
    chk("st_drained", 32'(out_valid), 32'd0);
    chk("st_flush_wait", 32'(flush_req), 32'd0);
    step();
    chk("st_flush_rise", 32'(flush_req), 32'd1);
    chk("st_no_ack_yet", 32'(mode_ack), 32'd0);
    step();
    chk("st_flush_held", 32'(flush_req), 32'd1);
    flush_done = 1'b1;
    step();
    chk("st_ack", 32'(mode_ack), 32'd1);
    chk("st_flush_drop", 32'(flush_req), 32'd0);
    chk("st_cur_mode", 32'(cur_mode), 32'd1);
    mode_req_valid = 1'b0;
    flush_done = 1'b0;
    step();

    // 4-way instance: illegal mode, then re-request of current mode
    mode_req_valid4 = 1'b1;
    mode_req4 = 2'd3;
    step();
    chk("w4_err", 32'(mode_err4), 32'd1);
    chk("w4_err_flush", 32'(flush_req4), 32'd0);
    chk("w4_err_mode", 32'(cur_mode4), 32'd0);
    mode_req_valid4 = 1'b0;
    step();
    chk("w4_err_pulse", 32'(mode_err4), 32'd0);
    mode_req_valid4 = 1'b1;
    mode_req4 = 2'd0;
    step();
    chk("w4_same_ack", 32'(mode_ack4), 32'd1);
    chk("w4_same_flush", 32'(flush_req4), 32'd0);
    mode_req_valid4 = 1'b0;
    step();
    chk("w4_ack_pulse", 32'(mode_ack4), 32'd0);

    // Reset during FLUSH abandons the change
    send(32'h0);
    send(32'h10);
    chk("rf_victim_pre", 32'(out_victim), 32'd1);
    mode_req_valid = 1'b1;
    mode_req = 2'd3;
    for (int i = 0; i < 20; i++) begin
      if (flush_req) break;
      step();
    end
    chk("rf_in_flush", 32'(flush_req), 32'd1);
    reset = 1'b0;
    step();
    chk("rf_flush_low", 32'(flush_req), 32'd0);
    chk("rf_cur_mode", 32'(cur_mode), 32'd0);
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_victim", 32'(out_victim), 32'd0);
    reset = 1'b1;
    mode_req_valid = 1'b0;
    step();
    chk("rf_no_ack", 32'(mode_ack), 32'd0);
    chk("rf_flush_stays_low", 32'(flush_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
